store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Parametrised, buffered successor to the combinational store lane formatter.
- Accepts store requests from the MEM stage and queues them in a DEPTH-entry FIFO.
- Formats each queued store into byte strobes and lane-aligned data for an XLEN-wide data memory port with a valid/ready handshake.
- Adds SD support for XLEN=64, backpressure, in-order drain, error reporting and optional two-beat splitting of boundary-crossing stores.

Parameters:
- XLEN, 32, data/port width in bits; legal values 32 or 64; BYTES = XLEN/8.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  FIFO can accept; equals !full.
- req_addr  in  ADDR_W  byte address.
- req_data  in  XLEN  rs2 data, LSB-justified.
- req_funct3  in  3  000 SB, 001 SH, 010 SW, 011 SD (SD legal only when XLEN=64).
- mem_valid  out  1  memory write beat valid.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  ADDR_W  BYTES-aligned address.
- mem_we  out  BYTES  byte write strobes.
- mem_wdata  out  XLEN  lane-aligned write data.
- empty  out  1  FIFO empty and no beat outstanding (fence/drain indicator).
- err  out  1  one-cycle pulse: dropped store.
- err_addr  out  ADDR_W  address of the dropped store; valid while err=1.

Behaviour:
- Reset: async assert clears the FIFO pointers and count, and returns the FSM to IDLE. Outputs during and after reset: mem_valid=0, mem_addr=0, mem_we=0, mem_wdata=0, err=0, err_addr=0, empty=1, req_ready=1.
- Enqueue: a request is accepted on req_valid && req_ready; it stores addr, data and funct3. No same-cycle bypass while full.
- Drain order: strictly FIFO. Count changes by +1 on accept, -1 on retire, and is unchanged when both happen in the same cycle.
- Decode at head, with off = addr mod BYTES and size = 1 << funct3[1:0]:
  - wide strobe = ((1<<size)-1) << off, width 2*BYTES;
  - wide data = zero-extended data << (8*off), width 2*XLEN;
  - the low half forms beat 0 at addr - off; the high half forms beat 1 at addr - off + BYTES;
  - the store crosses a boundary iff off + size > BYTES.
- Lanes not enabled in mem_we drive 0 in mem_wdata.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, load the head.
    - Illegal funct3 (1xx, or 011 when XLEN=32): pulse err with err_addr, retire the entry, stay IDLE. No memory beat is issued.
    - Otherwise register beat 0 and go to BEAT0.
  - BEAT0: mem_valid=1, with addr/we/wdata held stable until mem_ready.
    - On mem_ready with no beat 1: retire the entry; go to BEAT0 with the next head if one is present and legal, else IDLE.
    - On mem_ready with a beat 1: go to BEAT1.
  - BEAT1: mem_valid=1 with the beat-1 fields. On mem_ready, retire the entry and take the same next-step rule as BEAT0.
- Latency: a request accepted at edge N produces mem_valid at cycle N+1 at the earliest. Back-to-back single-beat stores sustain 1 beat per cycle while mem_ready=1.
- mem_valid never drops without a handshake.
- empty = (count==0) && state==IDLE.
- Reset mid-beat abandons the beat and all queued entries.

Optional Feature:
- Macro: STORE_BUFFER_SPLIT_EN.
- With the macro defined: boundary-crossing stores are issued as two beats (BEAT0 then BEAT1) at consecutive aligned addresses.
- Without the macro: a boundary-crossing store is dropped at the head, pulses err with err_addr = original address, issues no beat and is retired in one cycle. The BEAT1 state is not built.
- Non-crossing misaligned stores (e.g. SH at offset 1) issue as one beat in both builds.

Test Plan:
- SB: XLEN=32, SB addr 0x1003, data 0xAABBCCDD, mem_ready=1 -> mem_addr 0x1000, mem_we 1000, mem_wdata 0xDD000000, then empty=1.
- SH: SH addr 0x2002, data 0x00001234 -> mem_addr 0x2000, mem_we 1100, mem_wdata 0x12340000. SH addr 0x2001 -> mem_we 0110, mem_wdata 0x00123400.
- Crossing SW: SW addr 0x3003, data 0x11223344.
  - With the macro: beat 0x3000 / we 1000 / wdata 0x44000000, then beat 0x3004 / we 0111 / wdata 0x00112233.
  - Without the macro: err=1 for one cycle, err_addr 0x3003, mem_valid stays 0.
- Backpressure and full FIFO: DEPTH=4, mem_ready=0, push 4 SW at 0x0, 0x4, 0x8, 0xC -> req_ready=0 after the 4th accept, and mem_addr/mem_we/mem_wdata stay stable for 5 cycles. Raise mem_ready -> beats 0x0, 0x4, 0x8, 0xC on consecutive cycles, then empty=1.
- Illegal funct3: XLEN=32 with funct3 011 at 0x40, then funct3 101 at 0x44 -> two err pulses with err_addr 0x40 then 0x44, and no beats. XLEN=64 SD at 0x48 -> mem_we 0xFF.
- Reset mid-operation: assert rst_n=0 while mem_valid=1 with 2 entries queued -> mem_valid=0, mem_we=0 and empty=1 immediately (asynchronously). After release, no stale beat is issued.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : DEPTH-entry store queue between the MEM stage and an
//               XLEN-wide data memory port. Each queued store is formatted
//               into lane-aligned write data and byte strobes and issued with
//               a valid/ready handshake, strictly in order. Illegal funct3
//               encodings are dropped with a one-cycle err pulse.
//               Optional macro STORE_BUFFER_SPLIT_EN: boundary-crossing stores
//               are issued as two aligned beats; without it they are dropped
//               and reported through err.
// Revision    : 1.0 - initial buffered release
// ============================================================================
module store_buffer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_data,
  input  logic [2:0]        req_funct3,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              empty,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef STORE_BUFFER_SPLIT_EN
  localparam int NBEAT = 2;
`else
  localparam int NBEAT = 1;
`endif
  localparam int WIDE = NBEAT * XLEN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1
`ifdef STORE_BUFFER_SPLIT_EN
    , BEAT1 = 2'd2
`endif
  } state_t;

  // Queue storage; contents are qualified by the pointers, so no reset.
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];
  logic [2:0]        f3_q   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, sel_idx;
  logic [CNT_W-1:0]  count;
  state_t            state;

  logic              push, retire, load, beat_done, in_beat, have_next;
  logic [ADDR_W-1:0] hd_addr, hd_base;
  logic [XLEN-1:0]   hd_data;
  logic [2:0]        hd_f3;
  logic [OFF_W-1:0]  hd_off;
  logic [3:0]        hd_size;
  logic [2*BYTES-1:0] hd_we_wide;
  logic [WIDE-1:0]   hd_shift, hd_wd;
  logic              hd_cross, hd_legal, hd_ok;

`ifdef STORE_BUFFER_SPLIT_EN
  logic              b1_pend;
  logic [ADDR_W-1:0] b1_addr;
  logic [BYTES-1:0]  b1_we;
  logic [XLEN-1:0]   b1_wdata;
`endif

  assign req_ready = (count != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign empty     = (count == '0) && (state == IDLE);
  assign in_beat   = (state != IDLE);

  // While a beat is in flight the entry behind the head is decoded so the
  // next store can be loaded on the same edge the current one retires.
  assign sel_idx   = in_beat ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign have_next = in_beat ? (count > CNT_W'(1)) : (count != '0);

  assign hd_addr    = addr_q[sel_idx];
  assign hd_data    = data_q[sel_idx];
  assign hd_f3      = f3_q[sel_idx];
  assign hd_off     = hd_addr[OFF_W-1:0];
  assign hd_size    = 4'd1 << hd_f3[1:0];
  assign hd_base    = {hd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign hd_we_wide = (((2*BYTES)'(1) << hd_size) - (2*BYTES)'(1)) << hd_off;
  assign hd_cross   = |hd_we_wide[2*BYTES-1:BYTES];
  assign hd_legal   = !hd_f3[2] && ((XLEN == 64) || (hd_f3[1:0] != 2'b11));
  assign hd_shift   = WIDE'(hd_data) << {hd_off, 3'b000};

`ifdef STORE_BUFFER_SPLIT_EN
  assign hd_ok     = hd_legal;
  assign beat_done = mem_ready && (((state == BEAT0) && !b1_pend) || (state == BEAT1));
`else
  assign hd_ok     = hd_legal && !hd_cross;
  assign beat_done = mem_ready && (state == BEAT0);
`endif

  // An entry leaves the queue when its last beat is accepted or when it is dropped.
  assign retire = beat_done || ((state == IDLE) && have_next && !hd_ok);
  assign load   = have_next && hd_ok && ((state == IDLE) || beat_done);

  // Zero every byte lane whose strobe is off so unused lanes never carry rs2 bits.
  always_comb begin
    hd_wd = '0;
    for (int i = 0; i < NBEAT * BYTES; i++) begin
      hd_wd[8*i +: 8] = hd_we_wide[i] ? hd_shift[8*i +: 8] : 8'h00;
    end
  end

  // Capture accepted requests at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= req_addr;
      data_q[wr_ptr] <= req_data;
      f3_q[wr_ptr]   <= req_funct3;
    end
  end

  // Queue bookkeeping and the issue FSM with registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
`ifdef STORE_BUFFER_SPLIT_EN
      b1_pend   <= 1'b0;
      b1_addr   <= '0;
      b1_we     <= '0;
      b1_wdata  <= '0;
`endif
    end else begin
      err <= 1'b0;
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (retire) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(retire);

      if (load) begin
        state     <= BEAT0;
        mem_valid <= 1'b1;
        mem_addr  <= hd_base;
        mem_we    <= hd_we_wide[BYTES-1:0];
        mem_wdata <= hd_wd[XLEN-1:0];
`ifdef STORE_BUFFER_SPLIT_EN
        b1_pend   <= hd_cross;
        b1_addr   <= hd_base + ADDR_W'(BYTES);
        b1_we     <= hd_we_wide[2*BYTES-1:BYTES];
        b1_wdata  <= hd_wd[2*XLEN-1:XLEN];
`endif
      end
`ifdef STORE_BUFFER_SPLIT_EN
      else if ((state == BEAT0) && mem_ready && b1_pend) begin
        state     <= BEAT1;
        mem_addr  <= b1_addr;
        mem_we    <= b1_we;
        mem_wdata <= b1_wdata;
      end
`endif
      else if (beat_done) begin
        state     <= IDLE;
        mem_valid <= 1'b0;
        mem_addr  <= '0;
        mem_we    <= '0;
        mem_wdata <= '0;
      end else if ((state == IDLE) && have_next && !hd_ok) begin
        err      <= 1'b1;
        err_addr <= hd_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer (XLEN=32 and XLEN=64
//               instances). Directed table vectors, multi-cycle sequences and
//               a random run scored against a byte-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_store_buffer;

`ifdef STORE_BUFFER_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid, req_ready, mem_valid, mem_ready, empty, err;
  logic [31:0] req_addr, req_data, mem_addr, mem_wdata, err_addr;
  logic [2:0]  req_funct3;
  logic [3:0]  mem_we;

  logic        req_valid_w, req_ready_w, mem_valid_w, mem_ready_w, empty_w, err_w;
  logic [31:0] req_addr_w, mem_addr_w, err_addr_w;
  logic [63:0] req_data_w, mem_wdata_w;
  logic [2:0]  req_funct3_w;
  logic [7:0]  mem_we_w;

  store_buffer #(.XLEN(32), .DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .empty(empty), .err(err),
    .err_addr(err_addr)
  );

  store_buffer #(.XLEN(64), .DEPTH(4), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_w), .req_ready(req_ready_w),
    .req_addr(req_addr_w), .req_data(req_data_w), .req_funct3(req_funct3_w),
    .mem_valid(mem_valid_w), .mem_ready(mem_ready_w), .mem_addr(mem_addr_w),
    .mem_we(mem_we_w), .mem_wdata(mem_wdata_w), .empty(empty_w), .err(err_w),
    .err_addr(err_addr_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (XLEN=32) ----------------
  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wd;
  } ev_t;
  ev_t expq[$];

  // Walk the store byte by byte; each byte lands in the aligned word holding its address.
  task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    ev_t b[2];
    int sz, nb;
    logic [31:0] base;
    sz = 1 << f[1:0];
    if (f > 3'd2) begin
      expq.push_back('{1'b1, a, 4'h0, 32'h0});
    end else if (((a % 4) + sz > 4) && !SPLIT) begin
      expq.push_back('{1'b1, a, 4'h0, 32'h0});
    end else begin
      base = a & ~32'h3;
      b[0] = '{1'b0, base, 4'h0, 32'h0};
      b[1] = '{1'b0, base + 32'd4, 4'h0, 32'h0};
      nb = 1;
      for (int k = 0; k < sz; k++) begin
        logic [31:0] ab;
        int bi, ln;
        ab = a + k;
        bi = ((ab & ~32'h3) == base) ? 0 : 1;
        ln = int'(ab % 4);
        b[bi].we[ln] = 1'b1;
        b[bi].wd[8*ln +: 8] = d[8*k +: 8];
        if (bi == 1) nb = 2;
      end
      for (int j = 0; j < nb; j++) expq.push_back(b[j]);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    bit          is_err;   // when set, a0 holds the expected err_addr
    int          nb;
    logic [31:0] a0; logic [3:0] we0; logic [31:0] wd0;
    logic [31:0] a1; logic [3:0] we1; logic [31:0] wd1;
  } vec_t;
  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic push32(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_funct3 = f;
    for (int c = 0; c < 50 && !req_ready; c++) @(negedge clk);
    chk("push32 accepted", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic push64(input logic [31:0] a, input logic [63:0] d, input logic [2:0] f);
    @(negedge clk);
    req_valid_w = 1'b1; req_addr_w = a; req_data_w = d; req_funct3_w = f;
    for (int c = 0; c < 50 && !req_ready_w; c++) @(negedge clk);
    chk("push64 accepted", req_ready_w, 1);
    @(negedge clk);
    req_valid_w = 1'b0;
  endtask

  initial begin
    logic [31:0] ga[2], gd[2], ea[2];
    logic [3:0]  gw[2];
    int got, nerr, nbeat;
    bit seen_err, hold_v, drained;
    logic [31:0] hold_a, hold_d, se_addr;
    logic [3:0]  hold_w;
    ev_t ev;

    vecs[0] = '{32'h1003, 32'hAABBCCDD, 3'b000, 1'b0, 1, 32'h1000, 4'b1000, 32'hDD000000, 32'h0, 4'h0, 32'h0};
    vecs[1] = '{32'h2002, 32'h00001234, 3'b001, 1'b0, 1, 32'h2000, 4'b1100, 32'h12340000, 32'h0, 4'h0, 32'h0};
    vecs[2] = '{32'h2001, 32'h00001234, 3'b001, 1'b0, 1, 32'h2000, 4'b0110, 32'h00123400, 32'h0, 4'h0, 32'h0};
    vecs[3] = SPLIT ?
      '{32'h3003, 32'h11223344, 3'b010, 1'b0, 2, 32'h3000, 4'b1000, 32'h44000000, 32'h3004, 4'b0111, 32'h00112233} :
      '{32'h3003, 32'h11223344, 3'b010, 1'b1, 0, 32'h3003, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[4] = '{32'h0010, 32'hDEADBEEF, 3'b010, 1'b0, 1, 32'h0010, 4'b1111, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0};
    vecs[5] = '{32'h0005, 32'h1234567F, 3'b000, 1'b0, 1, 32'h0004, 4'b0010, 32'h00007F00, 32'h0, 4'h0, 32'h0};
    vecs[6] = SPLIT ?
      '{32'h0003, 32'h0000BEEF, 3'b001, 1'b0, 2, 32'h0000, 4'b1000, 32'hEF000000, 32'h0004, 4'b0001, 32'h000000BE} :
      '{32'h0003, 32'h0000BEEF, 3'b001, 1'b1, 0, 32'h0003, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[7] = '{32'h0040, 32'h12345678, 3'b011, 1'b1, 0, 32'h0040, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[8] = '{32'h0044, 32'h12345678, 3'b101, 1'b1, 0, 32'h0044, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[9] = '{32'h0050, 32'h12345678, 3'b111, 1'b1, 0, 32'h0050, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_funct3 = '0; mem_ready = 1'b1;
    req_valid_w = 1'b0; req_addr_w = '0; req_data_w = '0; req_funct3_w = '0; mem_ready_w = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("reset mem_valid/addr/we/wdata", {mem_valid, mem_addr, mem_we, mem_wdata}, '0);
    chk("reset err/err_addr", {err, err_addr}, '0);
    chk("reset empty/req_ready", {empty, req_ready}, 2'b11);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-reset idle outputs", {mem_valid, err, empty, req_ready, mem_we}, 8'b0011_0000);

    // ---- table vectors, one store at a time, mem_ready held high ----
    for (int i = 0; i < NV; i++) begin
      got = 0; seen_err = 0; se_addr = '0;
      push32(vecs[i].addr, vecs[i].data, vecs[i].f3);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (err) begin seen_err = 1; se_addr = err_addr; end
        if (mem_valid && got < 2) begin
          ga[got] = mem_addr; gw[got] = mem_we; gd[got] = mem_wdata; got++;
        end
      end
      chk($sformatf("v%0d err seen", i), seen_err, vecs[i].is_err);
      if (vecs[i].is_err) chk($sformatf("v%0d err_addr", i), se_addr, vecs[i].a0);
      chk($sformatf("v%0d beat count", i), got, vecs[i].nb);
      if (got >= 1 && vecs[i].nb >= 1)
        chk($sformatf("v%0d beat0", i), {ga[0], gw[0], gd[0]}, {vecs[i].a0, vecs[i].we0, vecs[i].wd0});
      if (got >= 2 && vecs[i].nb >= 2)
        chk($sformatf("v%0d beat1", i), {ga[1], gw[1], gd[1]}, {vecs[i].a1, vecs[i].we1, vecs[i].wd1});
      chk($sformatf("v%0d empty after", i), empty, 1);
    end

    // ---- backpressure and full FIFO ----
    mem_ready = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      req_valid = 1'b1; req_addr = 32'(j * 4); req_data = 32'hC0DE0000 + 32'(j); req_funct3 = 3'b010;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("full req_ready", req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      chk("stall beat stable", {mem_valid, mem_addr, mem_we, mem_wdata}, {1'b1, 32'h0, 4'hF, 32'hC0DE0000});
      @(negedge clk);
    end
    mem_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain beat %0d", j), {mem_valid, mem_addr, mem_we, mem_wdata},
          {1'b1, 32'(j * 4), 4'hF, 32'hC0DE0000 + 32'(j)});
      @(negedge clk);
    end
    chk("drain done empty/mem_valid", {empty, mem_valid}, 2'b10);

    // ---- two illegal funct3 back to back ----
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h40; req_data = 32'h0; req_funct3 = 3'b011;
    @(negedge clk);
    req_addr = 32'h44; req_funct3 = 3'b101;
    @(negedge clk);
    req_valid = 1'b0;
    nerr = 0; nbeat = 0; ea[0] = '0; ea[1] = '0;
    for (int c = 0; c < 10; c++) begin
      if (err) begin if (nerr < 2) ea[nerr] = err_addr; nerr++; end
      if (mem_valid) nbeat++;
      @(negedge clk);
    end
    chk("illegal pair err count", nerr, 2);
    chk("illegal pair err_addr order", {ea[0], ea[1]}, {32'h40, 32'h44});
    chk("illegal pair no beats", nbeat, 0);

    // ---- XLEN=64 instance: SD and upper-half SW ----
    push64(32'h48, 64'h0123456789ABCDEF, 3'b011);
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_valid_w && got == 0) begin
        chk("SD beat", {mem_addr_w, mem_we_w, mem_wdata_w}, {32'h48, 8'hFF, 64'h0123456789ABCDEF});
        got = 1;
      end
    end
    chk("SD beat issued", got, 1);
    push64(32'h4C, 64'hFFFFFFFFCAFEF00D, 3'b010);
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_valid_w && got == 0) begin
        chk("SW64 beat", {mem_addr_w, mem_we_w, mem_wdata_w}, {32'h48, 8'hF0, 64'hCAFEF00D_00000000});
        got = 1;
      end
    end
    chk("SW64 beat issued", got, 1);

    // ---- asynchronous reset mid-beat ----
    mem_ready = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      req_valid = 1'b1; req_addr = 32'h100 + 32'(4 * j); req_data = 32'h55AA0000; req_funct3 = 3'b010;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("pre-reset beat pending", mem_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset clears beat", {mem_valid, mem_we, empty, req_ready}, 7'b0_0000_11);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    nbeat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_valid) nbeat++;
    end
    chk("no stale beat after reset", nbeat, 0);

    // ---- random traffic against the reference model ----
    hold_v = 0; hold_a = '0; hold_w = '0; hold_d = '0; drained = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      if (err) begin
        chk("rnd err expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          ev = expq.pop_front();
          chk("rnd err kind", ev.is_err, 1);
          chk("rnd err_addr", err_addr, ev.addr);
        end
      end
      if (cyc < 800) begin
        int r;
        r = int'($urandom_range(0, 15));
        req_valid  = ($urandom_range(0, 9) < 6);
        req_addr   = $urandom_range(0, 63);
        req_data   = $urandom;
        req_funct3 = (r < 12) ? 3'(r % 3) : 3'(r - 9);
        mem_ready  = ($urandom_range(0, 9) < 7);
      end else begin
        req_valid = 1'b0;
        mem_ready = 1'b1;
      end
      if (hold_v)
        chk("rnd beat held", {mem_valid, mem_addr, mem_we, mem_wdata}, {1'b1, hold_a, hold_w, hold_d});
      if (mem_valid && mem_ready) begin
        chk("rnd beat expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          ev = expq.pop_front();
          chk("rnd beat kind", ev.is_err, 0);
          chk("rnd beat", {mem_addr, mem_we, mem_wdata}, {ev.addr, ev.we, ev.wd});
        end
      end
      hold_v = mem_valid && !mem_ready;
      hold_a = mem_addr; hold_w = mem_we; hold_d = mem_wdata;
      if (req_valid && req_ready) model_push(req_addr, req_data, req_funct3);
      if (cyc >= 800 && expq.size() == 0 && empty && !mem_valid && !err) begin
        drained = 1;
        break;
      end
    end
    chk("rnd drained", {drained, expq.size() == 0, empty}, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
